// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive and transmit paths.
//   UART_BYTE_W : width of one UART character
//   uart_byte_t : one UART character
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned UART_BYTE_W = 8;

    typedef logic [UART_BYTE_W-1:0] uart_byte_t;

endpackage : uart_pkg

// File: rtl/sync_fifo_fwft.sv
// ---------------------------------------------------------------------------
// sync_fifo_fwft
// Generic single-clock first-word-fall-through FIFO.
// The head entry is always visible on rd_data while empty=0.
//
// Parameters
//   WIDTH : data width
//   DEPTH : number of entries, power of two, >= 2
// Ports
//   clk     in   clock
//   reset   in   synchronous active-high reset (pointers and level only)
//   push    in   write wr_data this cycle (ignored when full and no pop)
//   wr_data in   write data
//   pop     in   consume head entry this cycle (ignored when empty)
//   rd_data out  head entry, valid while empty=0
//   level   out  occupancy 0..DEPTH
//   full    out  level == DEPTH
//   empty   out  level == 0
// ---------------------------------------------------------------------------
module sync_fifo_fwft #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LVL_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [LVL_W-1:0] level_reg;
    logic [LVL_W-1:0] level_next;

    logic do_push;
    logic do_pop;

    assign empty = (level_reg == '0);
    assign full  = (level_reg == LVL_W'(DEPTH));

    // A push while full is only legal when the head leaves in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        level_next = level_reg;
        if (do_push && !do_pop) begin
            level_next = level_reg + LVL_W'(1);
        end else if (do_pop && !do_push) begin
            level_next = level_reg - LVL_W'(1);
        end
    end

    // Storage carries no reset; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointers are exactly AW bits so they wrap from DEPTH-1 to 0 naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            level_reg <= level_next;
        end
    end

    // Fall-through read: a byte written in cycle N is visible in cycle N+1.
    assign rd_data = mem[rd_ptr_reg];
    assign level   = level_reg;

endmodule : sync_fifo_fwft

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Receive-side buffer behind the 8-bit UART receiver. Captures each byte
// flagged by a one-cycle in_valid pulse into a FWFT FIFO, presents it as a
// valid/ready stream, and keeps a sticky overflow flag plus a saturating
// count of receiver error rising edges.
//
// Optional feature macro: UART_RX_FIFO_TIMEOUT_EN
//   When defined, timeout asserts once the FIFO has been non-empty with no
//   new byte for TIMEOUT_CYCLES clocks. When undefined, timeout is tied 0.
//
// Parameters
//   DEPTH          : FIFO entries, power of two, >= 2
//   ERR_CNT_W      : width of the error edge counter
//   TIMEOUT_CYCLES : idle clocks before timeout (optional feature only)
// Ports
//   clk         in   clock
//   reset       in   synchronous active-high reset
//   in_data     in   received byte
//   in_valid    in   one-cycle pulse qualifying in_data
//   in_err      in   receiver error level
//   out_data    out  head byte, valid while out_valid=1
//   out_valid   out  FIFO non-empty
//   out_ready   in   host accepts head byte when out_valid & out_ready
//   level       out  occupancy 0..DEPTH
//   full        out  level == DEPTH
//   overflow    out  sticky: a byte was dropped while full
//   err_count   out  saturating count of in_err rising edges
//   clear_flags in   one-cycle pulse clearing overflow and err_count
//   timeout     out  idle timeout flag
// ---------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned ERR_CNT_W      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  uart_byte_t                 in_data,
    input  logic                       in_valid,
    input  logic                       in_err,
    output uart_byte_t                 out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       overflow,
    output logic [ERR_CNT_W-1:0]       err_count,
    input  logic                       clear_flags,
    output logic                       timeout
);

    // Reject configurations the pointer arithmetic cannot support.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("uart_rx_fifo: DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
    end

    logic fifo_empty;
    logic push;
    logic pop;
    logic drop;

    logic                 overflow_reg;
    logic [ERR_CNT_W-1:0] err_count_reg;
    logic                 in_err_q_reg;
    logic                 err_edge;

    assign out_valid = ~fifo_empty;
    assign pop       = out_valid & out_ready;
    assign push      = in_valid & (~full | pop);
    // A byte is lost only when full and the head is not leaving this cycle.
    assign drop      = in_valid & full & ~pop;
    assign err_edge  = in_err & ~in_err_q_reg;

    sync_fifo_fwft #(
        .WIDTH (UART_BYTE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wr_data (in_data),
        .pop     (pop),
        .rd_data (out_data),
        .level   (level),
        .full    (full),
        .empty   (fifo_empty)
    );

    // New events take priority over a coincident clear so none is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_reg  <= 1'b0;
            err_count_reg <= '0;
            in_err_q_reg  <= 1'b0;
        end else begin
            in_err_q_reg <= in_err;

            if (drop) begin
                overflow_reg <= 1'b1;
            end else if (clear_flags) begin
                overflow_reg <= 1'b0;
            end

            if (clear_flags) begin
                err_count_reg <= err_edge ? ERR_CNT_W'(1) : '0;
            end else if (err_edge && !(&err_count_reg)) begin
                err_count_reg <= err_count_reg + ERR_CNT_W'(1);
            end
        end
    end

    assign overflow  = overflow_reg;
    assign err_count = err_count_reg;

`ifdef UART_RX_FIFO_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [IDLE_W-1:0] idle_cnt_reg;

    // Counts clocks since the last accepted byte while data is waiting.
    always_ff @(posedge clk) begin
        if (reset) begin
            idle_cnt_reg <= '0;
        end else if (push || fifo_empty) begin
            idle_cnt_reg <= '0;
        end else if (idle_cnt_reg != IDLE_W'(TIMEOUT_CYCLES)) begin
            idle_cnt_reg <= idle_cnt_reg + IDLE_W'(1);
        end
    end

    assign timeout = out_valid & (idle_cnt_reg == IDLE_W'(TIMEOUT_CYCLES));
`else
    assign timeout = 1'b0;
`endif

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
// Directed self-checking bench for uart_rx_fifo (DEPTH=16, ERR_CNT_W=8,
// TIMEOUT_CYCLES=20). Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_err;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] level;
    logic       full;
    logic       overflow;
    logic [7:0] err_count;
    logic       clear_flags;
    logic       timeout;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .DEPTH          (16),
        .ERR_CNT_W      (8),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_err      (in_err),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .level       (level),
        .full        (full),
        .overflow    (overflow),
        .err_count   (err_count),
        .clear_flags (clear_flags),
        .timeout     (timeout)
    );

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        $display("check %-22s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic push_byte(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        in_data     = 8'h00;
        in_valid    = 1'b0;
        in_err      = 1'b0;
        out_ready   = 1'b0;
        clear_flags = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);

        // Empty with out_ready high: nothing pops
        out_ready = 1'b1;
        tick();
        chk("empty_rdy_level", 32'(level), 32'd0);
        chk("empty_rdy_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // First-byte latency: visible the cycle after the push
        push_byte(8'h55);
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_data", 32'(out_data), 32'h55);
        push_byte(8'hAA);
        push_byte(8'h01);
        chk("t1_level", 32'(level), 32'd3);
        chk("t1_head", 32'(out_data), 32'h55);

        // Drain in order on consecutive cycles
        out_ready = 1'b1;
        tick();
        chk("t1_pop1_data", 32'(out_data), 32'hAA);
        chk("t1_pop1_level", 32'(level), 32'd2);
        tick();
        chk("t1_pop2_data", 32'(out_data), 32'h01);
        tick();
        chk("t1_done_valid", 32'(out_valid), 32'd0);
        chk("t1_done_level", 32'(level), 32'd0);
        out_ready = 1'b0;

        // Fill to full, then one extra byte is dropped
        for (int i = 0; i < 16; i++) begin
            push_byte(8'(i));
        end
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_level", 32'(level), 32'd16);
        chk("fill_overflow", 32'(overflow), 32'd0);
        push_byte(8'hFF);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_level", 32'(level), 32'd16);
        chk("ovf_head", 32'(out_data), 32'h00);

        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        chk("clr_overflow", 32'(overflow), 32'd0);

        // Full with simultaneous push and pop: no drop
        chk("fullpp_head", 32'(out_data), 32'h00);
        out_ready = 1'b1;
        in_data   = 8'h77;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("fullpp_level", 32'(level), 32'd16);
        chk("fullpp_overflow", 32'(overflow), 32'd0);

        // Drain: 0x01..0x0F then 0x77 (0xFF never stored)
        out_ready = 1'b1;
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("drain_%0d", i), 32'(out_data), 32'(i));
            tick();
        end
        chk("drain_last", 32'(out_data), 32'h77);
        tick();
        chk("drain_empty", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Error edges: three long pulses, with garbage data and no in_valid
        for (int p = 0; p < 3; p++) begin
            in_err  = 1'b1;
            in_data = 8'hC3;
            repeat (5) tick();
            in_err  = 1'b0;
            repeat (5) tick();
        end
        chk("err_three", 32'(err_count), 32'd3);
        chk("err_no_store", 32'(level), 32'd0);

        for (int p = 0; p < 260; p++) begin
            in_err = 1'b1;
            tick();
            in_err = 1'b0;
            tick();
        end
        chk("err_saturate", 32'(err_count), 32'd255);

        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        chk("err_clear", 32'(err_count), 32'd0);

        // Clear coinciding with a new edge: the edge wins
        in_err      = 1'b1;
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        in_err      = 1'b0;
        chk("err_clr_edge", 32'(err_count), 32'd1);

        // Reset mid-stream discards buffered data
        for (int i = 0; i < 5; i++) begin
            push_byte(8'h10 + 8'(i));
        end
        chk("pre_rst_level", 32'(level), 32'd5);
        reset    = 1'b1;
        in_data  = 8'h99;
        in_valid = 1'b1;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_overflow", 32'(overflow), 32'd0);
        chk("mid_rst_errcnt", 32'(err_count), 32'd0);
        push_byte(8'h3C);
        chk("post_rst_data", 32'(out_data), 32'h3C);
        chk("post_rst_level", 32'(level), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("post_rst_empty", 32'(out_valid), 32'd0);

        // Idle timeout
        push_byte(8'h42);
`ifdef UART_RX_FIFO_TIMEOUT_EN
        repeat (19) tick();
        chk("tmo_before", 32'(timeout), 32'd0);
        tick();
        chk("tmo_assert", 32'(timeout), 32'd1);
        push_byte(8'h43);
        chk("tmo_push_clear", 32'(timeout), 32'd0);
        chk("tmo_level", 32'(level), 32'd2);
`else
        repeat (25) tick();
        chk("tmo_absent", 32'(timeout), 32'd0);
        chk("tmo_level", 32'(level), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_uart_rx_fifo

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer directly downstream of the 8-bit UART receiver.
- Captures each received byte, signalled by a one-cycle valid pulse, into a power-of-two FIFO.
- Presents bytes to the host side as a first-word-fall-through valid/ready stream.
- Tracks overflow (sticky) and framing errors (saturating count of err rising edges), so no byte or error is lost silently while the host is slow.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- ERR_CNT_W, 8, width of the saturating framing-error counter.
- TIMEOUT_CYCLES, 1000, idle clocks before timeout asserts; used only with the optional feature.

Ports:
- clk  input  1  clock
- reset  input  1  reset; synchronous, active-high
- in_data  input  8  received byte from the UART receiver
- in_valid  input  1  one-cycle pulse; in_data is valid this cycle
- in_err  input  1  receiver error level (framing/start/stop fault)
- out_data  output  8  head-of-FIFO byte; valid while out_valid=1
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  consumer accepts head byte when out_valid&out_ready
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- full  output  1  level==DEPTH
- overflow  output  1  sticky: a byte was dropped because the FIFO was full
- err_count  output  ERR_CNT_W  saturating count of in_err rising edges
- clear_flags  input  1  one-cycle pulse; clears overflow and err_count
- timeout  output  1  idle-timeout flag; tied 0 when the feature is absent

Behaviour:
- Reset: pointers=0, level=0, out_valid=0, full=0, overflow=0, err_count=0, timeout=0, and the in_err edge register=0. Memory contents are don't-care; out_data is don't-care while out_valid=0.
- Memory is an array of DEPTH x 8 regs. Read and write pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- push = in_valid & (~full | pop). pop = out_valid & out_ready.
- Latency: a byte pushed in cycle N appears on out_data with out_valid=1 in cycle N+1 if the FIFO was empty.
- out_data = mem[rd_ptr], a combinational read of registered storage. It must be stable while out_valid=1 and no pop occurs.
- level: +1 on push only, -1 on pop only, unchanged on both or neither.
- Full with simultaneous pop and in_valid: both occur, level stays DEPTH, no overflow.
- Full, in_valid, no pop: byte dropped, overflow<=1, pointers and level unchanged.
- Empty with out_ready=1: no pop, level stays 0.
- in_data is ignored whenever in_valid=0, including while in_err=1.
- err_count increments on an in_err 0->1 edge (in_err & ~in_err_q) and saturates at all-ones.
- clear_flags: overflow<=0 and err_count<=0. If an overflow or error edge occurs in the same cycle, it wins: overflow=1, err_count=1.
- Reset mid-stream discards all buffered bytes. in_valid during reset is ignored.

Optional Feature:
- Macro: UART_RX_FIFO_TIMEOUT_EN.
- When defined:
  - An idle counter, $clog2(TIMEOUT_CYCLES+1) bits, clears on every push and whenever the FIFO is empty.
  - Otherwise it increments, saturating at TIMEOUT_CYCLES.
  - timeout = out_valid & (idle counter == TIMEOUT_CYCLES).
  - timeout deasserts the cycle after a push or when the FIFO empties.
  - It lets the host drain short messages without polling.
- When undefined: no counter logic; timeout is tied 0.

Decomposition:
- Package uart_pkg holds UART_BYTE_W=8 and a typedef uart_byte_t. The receiver and transmitter share these.
- Natural sub-module: sync_fifo_fwft. It is a generic width/depth FWFT FIFO with push/pop/level/full/empty.
- uart_rx_fifo wraps sync_fifo_fwft and adds the overflow, err_count, clear and timeout logic.

Test Plan:
- Push 0x55, 0xAA, 0x01 with out_ready=0 -> level=3, out_data=0x55. Raise out_ready -> bytes 0x55, 0xAA, 0x01 pop in order on consecutive cycles, then out_valid=0, level=0.
- Fill 16 bytes 0x00..0x0F, then push 0xFF with out_ready=0 -> full=1, overflow=1, level=16. Drained order is 0x00..0x0F; 0xFF is absent.
- At full, push 0x77 with pop in the same cycle -> level stays 16, overflow=0, 0x77 emerges last.
- Pulse in_err high 3 separate times (each held 5 cycles) -> err_count=3. Then 260 edges -> err_count=255. clear_flags -> 0.
- Assert reset with level=5 -> next cycle level=0, out_valid=0, overflow=0. A push after reset -> out_data equals the new byte.
- With UART_RX_FIFO_TIMEOUT_EN and TIMEOUT_CYCLES=20, push 1 byte and hold out_ready=0 -> timeout=1 after 20 idle cycles. A push clears it next cycle. Without the macro -> timeout stays 0.
